// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types, twiddle constants and fixed-point multiply for the
// 8-point FFT.
//   DATA_W / FRAC_W : sample width and fractional bits (Q16.16)
//   sample_t        : signed DATA_W sample
//   cplx_t          : complex sample {re, im}
//   tw_sel_t        : butterfly twiddle selector (1, -j, W8^1, W8^3)
//   fx_mul          : signed fixed-point product, arithmetic shift by FRAC_W
// Build option: FFT8_ROUND_EN adds 2^(FRAC_W-1) before the shift (round-half-up);
// otherwise the product is truncated toward -inf.
package fft8_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    typedef enum logic [1:0] {
        TW_ONE,
        TW_MJ,
        TW_W81,
        TW_W83
    } tw_sel_t;

    // round(cos(pi/4) * 2^16)
    localparam sample_t TW_C = 32'h0000B505;
    localparam cplx_t   W8_1 = '{re: TW_C,  im: -TW_C};
    localparam cplx_t   W8_3 = '{re: -TW_C, im: -TW_C};

    localparam logic signed [2*DATA_W-1:0] MUL_RND = (2*DATA_W)'(1) << (FRAC_W-1);

    function automatic sample_t fx_mul(input sample_t a, input sample_t b);
        logic signed [2*DATA_W-1:0] w_a;
        logic signed [2*DATA_W-1:0] w_b;
        logic signed [2*DATA_W-1:0] w_prod;
        w_a    = (2*DATA_W)'(a);
        w_b    = (2*DATA_W)'(b);
        w_prod = w_a * w_b;
`ifdef FFT8_ROUND_EN
        w_prod = w_prod + MUL_RND;
`endif
        w_prod = w_prod >>> FRAC_W;
        return sample_t'(w_prod[DATA_W-1:0]);
    endfunction

endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: combinational radix-2 DIT butterfly, o_p = a + W*b, o_m = a - W*b.
//   TW   : twiddle selector (constant); 1 and -j are wiring/negation only
//   i_a  : upper input
//   i_b  : lower input (multiplied by the twiddle)
//   o_p  : sum output
//   o_m  : difference output
// Add/sub wrap modulo 2^DATA_W.
module fft8_bfly
    import fft8_pkg::*;
#(
    parameter tw_sel_t TW = TW_ONE
) (
    input  cplx_t i_a,
    input  cplx_t i_b,
    output cplx_t o_p,
    output cplx_t o_m
);

    cplx_t w_wb;

    generate
        if (TW == TW_ONE) begin : g_one
            always_comb w_wb = i_b;
        end else if (TW == TW_MJ) begin : g_mj
            // -j * (re + j*im) = im - j*re
            always_comb begin
                w_wb.re = i_b.im;
                w_wb.im = -i_b.re;
            end
        end else begin : g_mul
            localparam cplx_t W = (TW == TW_W81) ? W8_1 : W8_3;
            always_comb begin
                w_wb.re = fx_mul(W.re, i_b.re) - fx_mul(W.im, i_b.im);
                w_wb.im = fx_mul(W.re, i_b.im) + fx_mul(W.im, i_b.re);
            end
        end
    endgenerate

    always_comb begin
        o_p.re = i_a.re + w_wb.re;
        o_p.im = i_a.im + w_wb.im;
        o_m.re = i_a.re - w_wb.re;
        o_m.im = i_a.im - w_wb.im;
    end

endmodule

// File: rtl/fft_8point.sv
// fft_8point: fully parallel, 3-stage pipelined 8-point radix-2 DIT FFT on
// real Q16.16 samples. One frame per clock, latency 3 clocks, unscaled.
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset, clears every pipeline register
//   in0_r..in7_r   : real samples x[0]..x[7] (imaginary parts are zero)
//   out0_r..out7_r : real part of X[0]..X[7], natural order
//   out0_i..out7_i : imaginary part of X[0]..X[7]
// Build option: FFT8_ROUND_EN selects round-half-up twiddle products (see fft8_pkg).
module fft_8point
    import fft8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_r,
    input  logic [DATA_W-1:0] in1_r,
    input  logic [DATA_W-1:0] in2_r,
    input  logic [DATA_W-1:0] in3_r,
    input  logic [DATA_W-1:0] in4_r,
    input  logic [DATA_W-1:0] in5_r,
    input  logic [DATA_W-1:0] in6_r,
    input  logic [DATA_W-1:0] in7_r,
    output logic [DATA_W-1:0] out0_r,
    output logic [DATA_W-1:0] out1_r,
    output logic [DATA_W-1:0] out2_r,
    output logic [DATA_W-1:0] out3_r,
    output logic [DATA_W-1:0] out4_r,
    output logic [DATA_W-1:0] out5_r,
    output logic [DATA_W-1:0] out6_r,
    output logic [DATA_W-1:0] out7_r,
    output logic [DATA_W-1:0] out0_i,
    output logic [DATA_W-1:0] out1_i,
    output logic [DATA_W-1:0] out2_i,
    output logic [DATA_W-1:0] out3_i,
    output logic [DATA_W-1:0] out4_i,
    output logic [DATA_W-1:0] out5_i,
    output logic [DATA_W-1:0] out6_i,
    output logic [DATA_W-1:0] out7_i
);

    // Stage-1 upper input per butterfly; lower input is +4 (bit-reversed pairing).
    localparam int unsigned S1_A [4] = '{0, 2, 1, 3};
    localparam tw_sel_t     S2_TW[2] = '{TW_ONE, TW_MJ};
    localparam tw_sel_t     S3_TW[4] = '{TW_ONE, TW_W81, TW_MJ, TW_W83};

    cplx_t w_x  [8];
    cplx_t w_s1 [8];
    cplx_t w_s2 [8];
    cplx_t w_s3 [8];
    cplx_t r_s1 [8];
    cplx_t r_s2 [8];
    cplx_t r_s3 [8];

    always_comb begin
        w_x[0] = '{re: in0_r, im: '0};
        w_x[1] = '{re: in1_r, im: '0};
        w_x[2] = '{re: in2_r, im: '0};
        w_x[3] = '{re: in3_r, im: '0};
        w_x[4] = '{re: in4_r, im: '0};
        w_x[5] = '{re: in5_r, im: '0};
        w_x[6] = '{re: in6_r, im: '0};
        w_x[7] = '{re: in7_r, im: '0};
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_st1
            fft8_bfly #(.TW(TW_ONE)) u_bf (
                .i_a(w_x[S1_A[g]]),
                .i_b(w_x[S1_A[g] + 4]),
                .o_p(w_s1[2*g]),
                .o_m(w_s1[2*g + 1])
            );
        end

        // Two 4-point groups: spans of 2 inside each group of 4.
        for (g = 0; g < 4; g++) begin : g_st2
            fft8_bfly #(.TW(S2_TW[g % 2])) u_bf (
                .i_a(r_s1[4*(g/2) + (g%2)]),
                .i_b(r_s1[4*(g/2) + (g%2) + 2]),
                .o_p(w_s2[4*(g/2) + (g%2)]),
                .o_m(w_s2[4*(g/2) + (g%2) + 2])
            );
        end

        for (g = 0; g < 4; g++) begin : g_st3
            fft8_bfly #(.TW(S3_TW[g])) u_bf (
                .i_a(r_s2[g]),
                .i_b(r_s2[g + 4]),
                .o_p(w_s3[g]),
                .o_m(w_s3[g + 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '{default: '0};
            r_s2 <= '{default: '0};
            r_s3 <= '{default: '0};
        end else begin
            r_s1 <= w_s1;
            r_s2 <= w_s2;
            r_s3 <= w_s3;
        end
    end

    assign out0_r = r_s3[0].re;
    assign out1_r = r_s3[1].re;
    assign out2_r = r_s3[2].re;
    assign out3_r = r_s3[3].re;
    assign out4_r = r_s3[4].re;
    assign out5_r = r_s3[5].re;
    assign out6_r = r_s3[6].re;
    assign out7_r = r_s3[7].re;
    assign out0_i = r_s3[0].im;
    assign out1_i = r_s3[1].im;
    assign out2_i = r_s3[2].im;
    assign out3_i = r_s3[3].im;
    assign out4_i = r_s3[4].im;
    assign out5_i = r_s3[5].im;
    assign out6_i = r_s3[6].im;
    assign out7_i = r_s3[7].im;

endmodule

// File: tb/tb_fft_8point.sv
`timescale 1ns/1ps
module tb_fft_8point;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0][31:0]  in_r;
    logic [7:0][31:0]  out_r;
    logic [7:0][31:0]  out_i;

    always #5 clk = ~clk;

    fft_8point dut (
        .clk   (clk),
        .rst   (rst),
        .in0_r (in_r[0]), .in1_r (in_r[1]), .in2_r (in_r[2]), .in3_r (in_r[3]),
        .in4_r (in_r[4]), .in5_r (in_r[5]), .in6_r (in_r[6]), .in7_r (in_r[7]),
        .out0_r(out_r[0]), .out1_r(out_r[1]), .out2_r(out_r[2]), .out3_r(out_r[3]),
        .out4_r(out_r[4]), .out5_r(out_r[5]), .out6_r(out_r[6]), .out7_r(out_r[7]),
        .out0_i(out_i[0]), .out1_i(out_i[1]), .out2_i(out_i[2]), .out3_i(out_i[3]),
        .out4_i(out_i[4]), .out5_i(out_i[5]), .out6_i(out_i[6]), .out7_i(out_i[7])
    );

    typedef struct packed {
        logic [7:0][31:0] re;
        logic [7:0][31:0] im;
        logic [31:0]      due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc         = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    // W8^m in Q16.16, m = 0..7
    localparam int WR [8] = '{65536,  46341,      0, -46341, -65536, -46341,     0, 46341};
    localparam int WI [8] = '{    0, -46341, -65536, -46341,      0,  46341, 65536, 46341};

    task automatic check_frame(input string tag, input logic [7:0][31:0] er,
                               input logic [7:0][31:0] ei);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            assert (out_r[k] === er[k]) else begin
                miscompares++;
                $error("FAIL %s@cyc%0d X%0d_r got %h want %h", tag, cyc, k, out_r[k], er[k]);
            end
            vectors++;
            assert (out_i[k] === ei[k]) else begin
                miscompares++;
                $error("FAIL %s@cyc%0d X%0d_i got %h want %h", tag, cyc, k, out_i[k], ei[k]);
            end
        end
    endtask

    // Advance one edge; compare the frame due now, otherwise expect a cleared pipeline.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_frame("frame", e.re, e.im);
        end else begin
            check_frame("idle", '0, '0);
        end
    endtask

    // Integer-valued samples (xi * 1.0): every twiddle product is exact, so a
    // direct DFT gives bit-exact bins in both rounding builds.
    task automatic drive_model(input int xi[8]);
        exp_t e;
        int   sr, si;
        for (int k = 0; k < 8; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 8; n++) begin
                sr += xi[n] * WR[(n * k) % 8];
                si += xi[n] * WI[(n * k) % 8];
            end
            e.re[k] = 32'(sr);
            e.im[k] = 32'(si);
        end
        for (int n = 0; n < 8; n++) in_r[n] = 32'(xi[n] * 65536);
        e.due = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic drive_hand(input logic [7:0][31:0] x, input logic [7:0][31:0] er,
                              input logic [7:0][31:0] ei);
        exp_t e;
        in_r  = x;
        e.re  = er;
        e.im  = ei;
        e.due = cyc + 3;
        sb.push_back(e);
    endtask

    initial begin
        int               xi[8];
        logic [7:0][31:0] mix_x, mix_re, mix_im;
        logic [7:0][31:0] tny_x, tny_re, tny_im;
        logic [31:0]      r1, r5;

        // Packed order is {X7, ..., X0}.
        mix_x  = {32'h0, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h00010000, 32'h00010000};
        mix_re = {32'h0000B505, 32'h00010000, 32'hFFFF4AFB, 32'h00020000,
                  32'hFFFF4AFB, 32'h00010000, 32'h0000B505, 32'h00040000};
        mix_im = {32'h0001B505, 32'h00010000, 32'hFFFFB505, 32'h00000000,
                  32'h00004AFB, 32'hFFFF0000, 32'hFFFE4AFB, 32'h00000000};
`ifdef FFT8_ROUND_EN
        r1 = 32'h00000001;
        r5 = 32'hFFFFFFFF;
`else
        r1 = 32'h00000000;
        r5 = 32'h00000000;
`endif
        // x[1] = one LSB: exposes truncation/rounding of the W8^1 / W8^3 products.
        tny_x  = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000001, 32'h0};
        tny_re = {32'h00000001, 32'h00000000, r5, 32'hFFFFFFFF,
                  32'hFFFFFFFF, 32'h00000000, r1, 32'h00000001};
        tny_im = {32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

        // Reset with garbage inputs.
        rst = 1'b0;
        for (int n = 0; n < 8; n++) in_r[n] = 32'h1357_9BDF + 32'(n * 32'h0101_0101);
        #3;
        check_frame("rst_async", '0, '0);
        repeat (3) tick();

        // Release with zero inputs; outputs stay 0 for 3 edges.
        rst = 1'b1;
        xi  = '{default: 0};
        repeat (3) begin
            drive_model(xi);
            tick();
        end

        xi = '{1, 0, 0, 0, 0, 0, 0, 0};
        drive_model(xi);
        tick();

        xi = '{1, 1, 1, 1, 1, 1, 1, 1};
        drive_model(xi);
        tick();

        repeat (8) begin
            drive_hand(mix_x, mix_re, mix_im);
            tick();
        end

        drive_hand(tny_x, tny_re, tny_im);
        tick();

        // Back-to-back distinct frames.
        repeat (20) begin
            for (int n = 0; n < 8; n++) xi[n] = int'($urandom_range(200)) - 100;
            drive_model(xi);
            tick();
        end

        // Mid-cycle reset with frames in flight: outputs clear at once.
        #2;
        rst = 1'b0;
        #1;
        check_frame("rst_mid", '0, '0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) begin
            for (int n = 0; n < 8; n++) xi[n] = int'($urandom_range(2000)) - 1000;
            drive_model(xi);
            tick();
        end
        xi = '{default: 0};
        repeat (4) begin
            drive_model(xi);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
